// File: rtl/uart_rx_frame_parser.sv
// Parses HEAD0 HEAD1 LEN payload CSUM frames from a UART byte stream and replays the payload over valid/ready.
// Optional inter-byte timeout is compiled in when UART_PARSER_TIMEOUT_EN is defined.
module uart_rx_frame_parser #(
  parameter int         P_MAX_LEN = 16,
  parameter logic [7:0] P_HEAD0   = 8'h55,
  parameter logic [7:0] P_HEAD1   = 8'hAA,
  parameter int         P_TIMEOUT = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_pkt_data,
  output logic       o_pkt_valid,
  output logic       o_pkt_last,
  input  logic       i_pkt_ready,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun
);

  localparam int         AW        = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD1,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_OUTPUT
  } state_t;

  state_t state_reg, state_next;

  logic [7:0] len_reg;
  logic [7:0] csum_reg;
  logic [7:0] idx_reg;
  logic [7:0] buf_mem [0:P_MAX_LEN-1];

  logic [7:0] pkt_data_reg;
  logic       pkt_valid_reg;
  logic       pkt_last_reg;
  logic       err_reg;
  logic [1:0] err_code_reg;
  logic       overrun_reg;

  logic          len_ok;
  logic          xfer;
  logic          err_set;
  logic [1:0]    err_code_set;
  logic          overrun_set;
  logic          load_first;
  logic          advance;
  logic          timeout_hit;
  logic [AW-1:0] rd_addr;

  assign len_ok  = (i_rx_data != 8'd0) && (i_rx_data <= MAX_LEN_B);
  assign xfer    = pkt_valid_reg && i_pkt_ready;
  assign rd_addr = load_first ? '0 : AW'(idx_reg + 8'd1);

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_active;

  assign tmo_active  = state_reg inside {S_HEAD1, S_LEN, S_PAYLOAD, S_CSUM};
  assign timeout_hit = tmo_active && !i_rx_valid && (tmo_cnt_reg == TW'(P_TIMEOUT - 1));

  // Counts silent cycles only while a frame is partially received.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt_reg <= '0;
    end else if (!tmo_active || i_rx_valid || timeout_hit) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    err_set      = 1'b0;
    err_code_set = 2'd0;
    overrun_set  = 1'b0;
    load_first   = 1'b0;
    advance      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_data == P_HEAD0)) begin
          state_next = S_HEAD1;
        end
      end
      S_HEAD1: begin
        if (i_rx_valid) begin
          if (i_rx_data == P_HEAD1) begin
            state_next = S_LEN;
          end else if (i_rx_data == P_HEAD0) begin
            state_next = S_HEAD1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_LEN: begin
        if (i_rx_valid) begin
          if (len_ok) begin
            state_next = S_PAYLOAD;
          end else begin
            state_next   = S_IDLE;
            err_set      = 1'b1;
            err_code_set = 2'd1;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_rx_valid && (idx_reg == len_reg - 8'd1)) begin
          state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (i_rx_valid) begin
          if (i_rx_data == csum_reg) begin
            state_next = S_OUTPUT;
            load_first = 1'b1;
          end else begin
            state_next   = S_IDLE;
            err_set      = 1'b1;
            err_code_set = 2'd2;
          end
        end
      end
      S_OUTPUT: begin
        // No backpressure upstream, so anything arriving now is lost.
        overrun_set = i_rx_valid;
        if (xfer) begin
          if (pkt_last_reg) begin
            state_next = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (timeout_hit) begin
      state_next   = S_IDLE;
      err_set      = 1'b1;
      err_code_set = 2'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state_reg == S_PAYLOAD) && i_rx_valid) begin
      buf_mem[idx_reg[AW-1:0]] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_reg       <= 8'd0;
      csum_reg      <= 8'd0;
      idx_reg       <= 8'd0;
      pkt_data_reg  <= 8'd0;
      pkt_valid_reg <= 1'b0;
      pkt_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= 2'd0;
      overrun_reg   <= 1'b0;
    end else begin
      err_reg     <= err_set;
      overrun_reg <= overrun_set;
      if (err_set) begin
        err_code_reg <= err_code_set;
      end

      case (state_reg)
        S_LEN: begin
          if (i_rx_valid && len_ok) begin
            len_reg  <= i_rx_data;
            csum_reg <= i_rx_data;
            idx_reg  <= 8'd0;
          end
        end
        S_PAYLOAD: begin
          if (i_rx_valid) begin
            csum_reg <= csum_reg + i_rx_data;
            idx_reg  <= idx_reg + 8'd1;
          end
        end
        S_CSUM: begin
          if (load_first) begin
            idx_reg <= 8'd0;
          end
        end
        S_OUTPUT: begin
          if (advance) begin
            idx_reg <= idx_reg + 8'd1;
          end
        end
        default: begin
        end
      endcase

      // idx_reg tracks the index of the byte currently presented downstream.
      if (load_first || advance) begin
        pkt_data_reg <= buf_mem[rd_addr];
      end
      if (load_first) begin
        pkt_valid_reg <= 1'b1;
        pkt_last_reg  <= (len_reg == 8'd1);
      end else if (advance) begin
        pkt_last_reg <= ((idx_reg + 8'd2) == len_reg);
      end else if (xfer && pkt_last_reg) begin
        pkt_valid_reg <= 1'b0;
        pkt_last_reg  <= 1'b0;
      end
    end
  end

  assign o_pkt_data  = pkt_data_reg;
  assign o_pkt_valid = pkt_valid_reg;
  assign o_pkt_last  = pkt_last_reg;
  assign o_err       = err_reg;
  assign o_err_code  = err_code_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: good/bad frames, stalls, overruns, timeout and reset.
module tb_uart_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       pkt_ready;
  logic       err;
  logic [1:0] err_code;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int overrun_cnt = 0;
  int err_cnt     = 0;
  int stall_seen  = 0;
  int stall_bad   = 0;
  logic [7:0] xq[$];
  logic       lq[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  uart_rx_frame_parser #(
    .P_MAX_LEN(16),
    .P_HEAD0  (8'h55),
    .P_HEAD1  (8'hAA),
    .P_TIMEOUT(20)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_pkt_data (pkt_data),
    .o_pkt_valid(pkt_valid),
    .o_pkt_last (pkt_last),
    .i_pkt_ready(pkt_ready),
    .o_err      (err),
    .o_err_code (err_code),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the next posedge will use.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        stall_seen++;
        if (!(pkt_valid && pkt_data == prev_data && pkt_last == prev_last)) stall_bad++;
      end
      if (pkt_valid && pkt_ready) begin
        xq.push_back(pkt_data);
        lq.push_back(pkt_last);
      end
      if (overrun) overrun_cnt++;
      if (err) err_cnt++;
      prev_stall = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
      prev_last  = pkt_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int ov0;
    int err0;

    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    pkt_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 32'({pkt_valid, pkt_last, err, overrun, err_code, pkt_data}), 32'd0);
    rst = 1'b0;
    tick();

    // Basic 3-byte frame at full ready
    send(8'h55); send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("t1_not_early", 32'(pkt_valid), 32'd0);
    send(8'h69);
    check("t1_byte0", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b0, 8'h11}));
    tick();
    check("t1_byte1", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b0, 8'h22}));
    tick();
    check("t1_byte2", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b1, 8'h33}));
    tick();
    check("t1_done", 32'(pkt_valid), 32'd0);
    check("t1_no_err", 32'(err_cnt), 32'd0);

    // Checksum error then good single-byte frame
    send(8'h55); send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    check("t2_csum_err", 32'({err, err_code, pkt_valid}), 32'({1'b1, 2'd2, 1'b0}));
    tick();
    check("t2_err_pulse_hold", 32'({err, err_code}), 32'({1'b0, 2'd2}));
    send(8'h55); send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
    check("t2_single", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b1, 8'h7F}));
    tick();
    check("t2_single_done", 32'(pkt_valid), 32'd0);

    // Repeated HEAD0, then length out of range at both ends
    send(8'h55); send(8'h55); send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
    check("t3_head_repeat", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b1, 8'h05}));
    tick();
    send(8'h55); send(8'hAA); send(8'h00);
    check("t3_len_zero", 32'({err, err_code}), 32'({1'b1, 2'd1}));
    tick();
    check("t3_len_zero_pulse", 32'(err), 32'd0);
    send(8'h55); send(8'hAA); send(8'h11);
    check("t3_len_big", 32'({err, err_code}), 32'({1'b1, 2'd1}));
    tick();

    // Byte arriving on the last-byte transfer cycle is dropped
    send(8'h55); send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
    check("t4_byte0", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b0, 8'h01}));
    tick();
    check("t4_byte1", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b1, 8'h02}));
    send(8'h55);
    check("t4_overrun", 32'({pkt_valid, overrun}), 32'({1'b0, 1'b1}));
    send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
    tick();
    check("t4_dropped_head", 32'(pkt_valid), 32'd0);

    // Ready toggling with an injected byte during output
    base = xq.size();
    ov0  = overrun_cnt;
    send(8'h55); send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    pkt_ready = 1'b0;
    send(8'h69);
    for (int i = 0; i < 10; i++) begin
      pkt_ready = (i % 2) == 1;
      if (i == 2) begin
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (i == 2) check("t5_overrun_pulse", 32'(overrun), 32'd1);
    end
    pkt_ready = 1'b1;
    check("t5_count", 32'(xq.size() - base), 32'd3);
    if (xq.size() - base == 3) begin
      check("t5_data", 32'({xq[base], xq[base+1], xq[base+2]}), 32'({8'h11, 8'h22, 8'h33}));
      check("t5_last", 32'({lq[base], lq[base+1], lq[base+2]}), 32'({1'b0, 1'b0, 1'b1}));
    end
    check("t5_overrun_cnt", 32'(overrun_cnt - ov0), 32'd1);
    check("t5_stall_seen", 32'(stall_seen > 0), 32'd1);
    check("t5_stall_stable", 32'(stall_bad), 32'd0);

    // Inter-byte silence
    err0 = err_cnt;
    send(8'h55); send(8'hAA); send(8'h02); send(8'h10);
    for (int k = 1; k <= 21; k++) begin
      tick();
`ifdef UART_PARSER_TIMEOUT_EN
      if (k == 19) check("t6_not_yet", 32'(err), 32'd0);
      if (k == 20) check("t6_timeout", 32'({err, err_code}), 32'({1'b1, 2'd3}));
      if (k == 21) check("t6_pulse_end", 32'(err), 32'd0);
`endif
    end
`ifdef UART_PARSER_TIMEOUT_EN
    check("t6_err_count", 32'(err_cnt - err0), 32'd1);
`else
    check("t6_no_timeout", 32'({err_cnt == err0, err_code == 2'd3}), 32'({1'b1, 1'b0}));
`endif

    // Asynchronous reset clears held error code immediately
    rst = 1'b1;
    #1;
    check("t7_async_code", 32'(err_code), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-payload, then a clean frame
    send(8'h55); send(8'hAA); send(8'h02); send(8'h10);
    rst = 1'b1;
    #1;
    check("t7_rst_payload", 32'({pkt_valid, pkt_last, err, overrun, err_code, pkt_data}), 32'd0);
    tick();
    rst = 1'b0;
    send(8'h55); send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
    check("t7_after_rst", 32'({pkt_valid, pkt_last, pkt_data}), 32'({1'b1, 1'b1, 8'h7F}));
    tick();

    // Reset while stalled in output
    pkt_ready = 1'b0;
    send(8'h55); send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
    check("t8_presented", 32'({pkt_valid, pkt_data}), 32'({1'b1, 8'h01}));
    rst = 1'b1;
    #1;
    check("t8_rst_output", 32'({pkt_valid, pkt_last, pkt_data}), 32'd0);
    tick();
    rst = 1'b0;
    pkt_ready = 1'b1;
    repeat (3) tick();
    check("t8_no_partial", 32'(pkt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
